// File: rtl/mem_responder.sv
// mem_responder: single-port 32-bit memory target with a fixed, parameterised
// number of wait states before a one-cycle ack.
//
// Parameters
//   ADDR_BITS   : word-address width; store depth is 2**ADDR_BITS words (<= 29)
//   WAIT_CYCLES : wait states before ack, 0..15
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   addr_i[31:0] : byte address, bits [1:0] ignored
//   data_i[31:0] : write data
//   we_i / rd_i  : level requests held until ack; both high means write
//   data_o[31:0] : read data, valid with ack_o
//   ack_o        : one-cycle completion strobe
//   err_o        : out-of-range flag, valid with ack_o
//   txn_count_o  : completed-transaction count, wraps at 16 bits
//
// Optional feature: define MEM_RESPONDER_ERR_EN to flag accesses whose upper
// address bits [31:ADDR_BITS+2] are non-zero. Without it those bits alias.

module mem_responder #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        we_i,
  input  logic        rd_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic [15:0] txn_count_o
);

  localparam int unsigned DEPTH   = 1 << ADDR_BITS;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TXN_W   = 16;
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_wait_cnt;
  logic [ADDR_BITS-1:0]   r_idx;
  logic [31:0]            r_wdata;
  logic                   r_we;
  logic [31:0]            r_data;
  logic [TXN_W-1:0]       r_txn_cnt;
  logic [31:0]            r_mem [DEPTH];

  logic                   w_req;
  logic                   w_start;
  logic                   w_enter_ack;
  logic [ADDR_BITS-1:0]   w_in_idx;
  logic [ADDR_BITS-1:0]   w_acc_idx;
  logic [31:0]            w_acc_data;
  logic                   w_acc_we;
  logic                   w_acc_oor;
  logic                   w_unused_addr;

  assign w_req    = rd_i | we_i;
  assign w_start  = (r_state == S_IDLE) && w_req;
  assign w_in_idx = addr_i[ADDR_BITS+1:2];

  // Byte-lane bits never matter; upper bits only matter with the error check.
  assign w_unused_addr = ^{addr_i[1:0], addr_i[31:ADDR_BITS+2]};

  // Edge that moves the FSM into S_ACK: commit point of every transaction.
  assign w_enter_ack = (w_start && NO_WAIT) ||
                       ((r_state == S_WAIT) && (r_wait_cnt == CNT_W'(1)));

  // With zero wait states the commit happens on the sampling edge itself,
  // so the live inputs must be used instead of the latched copies.
  assign w_acc_idx  = (r_state == S_IDLE) ? w_in_idx : r_idx;
  assign w_acc_data = (r_state == S_IDLE) ? data_i   : r_wdata;
  assign w_acc_we   = (r_state == S_IDLE) ? we_i     : r_we;

`ifdef MEM_RESPONDER_ERR_EN
  logic r_oor;
  logic r_err;
  logic w_in_oor;

  assign w_in_oor  = (addr_i >> (ADDR_BITS + 2)) != 32'd0;
  assign w_acc_oor = (r_state == S_IDLE) ? w_in_oor : r_oor;

  // Out-of-range flag latched with the request, presented during ack only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_oor <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_start) r_oor <= w_in_oor;
      r_err <= w_enter_ack && w_acc_oor;
    end
  end

  assign err_o = r_err;
`else
  assign w_acc_oor = 1'b0;
  assign err_o     = 1'b0;
`endif

  // Control FSM with read-data and transaction-count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_data     <= '0;
      r_txn_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_idx      <= w_in_idx;
            r_wdata    <= data_i;
            r_we       <= we_i;
            r_wait_cnt <= WAIT_LD;
            r_state    <= NO_WAIT ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt - CNT_W'(1);
          if (r_wait_cnt == CNT_W'(1)) r_state <= S_ACK;
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_enter_ack) begin
        r_txn_cnt <= r_txn_cnt + TXN_W'(1);
        if (w_acc_oor)      r_data <= '0;
        else if (!w_acc_we) r_data <= r_mem[w_acc_idx];
      end
    end
  end

  // Backing store, deliberately not reset; writes are blocked during reset
  // so an aborted transaction can never commit.
  always_ff @(posedge clk) begin
    if (rst && w_enter_ack && w_acc_we && !w_acc_oor) begin
      r_mem[w_acc_idx] <= w_acc_data;
    end
  end

  assign ack_o       = (r_state == S_ACK);
  assign data_o      = r_data;
  assign txn_count_o = r_txn_cnt;

endmodule
